// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the fetch PC, a single-outstanding imem request, a one-entry
// response buffer and the IF/ID register. Optional: `define IFU_MISALIGN_CHECK_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_write_en_i,
  input  logic        if_id_write_en_i,
  input  logic        if_id_flush_i,
  input  logic        redirect_req_i,
  input  logic [31:0] redirect_target_i,
  input  logic        halt_detected_i,
  output logic        imem_req_valid_o,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc_plus4_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] pc_o,
  output logic        halted_o,
  output logic        misaligned_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DROP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        target_misaligned;
  logic        avail;
  logic [31:0] fetch_data;
  logic        xfer;
  logic        req_valid;
  logic        req_accept;

`ifdef IFU_MISALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;
  assign target            = redirect_target_i;
  assign target_misaligned = (redirect_target_i[1:0] != 2'b00);
  assign misaligned_o      = misaligned_q;
`else
  logic unused_target_bits;
  assign unused_target_bits = ^redirect_target_i[1:0];
  assign target             = {redirect_target_i[31:2], 2'b00};
  assign target_misaligned  = 1'b0;
  assign misaligned_o       = 1'b0;
`endif

  assign pc_plus4   = pc_q + 32'd4;
  assign avail      = ((state_q == ST_WAIT) && imem_rsp_valid_i) || buf_valid_q;
  assign fetch_data = buf_valid_q ? buf_data_q : imem_rsp_data_i;
  assign xfer       = avail && if_id_write_en_i && pc_write_en_i && !if_id_flush_i
                      && !redirect_req_i && !halt_detected_i;
  // A buffered word blocks new requests until IF/ID has taken it.
  assign req_valid  = !rst_i && !redirect_req_i && !halt_detected_i && !buf_valid_q
                      && ((state_q == ST_IDLE) || ((state_q == ST_WAIT) && xfer));
  assign req_accept = req_valid && imem_req_ready_i;

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = (state_q == ST_WAIT) ? pc_plus4 : pc_q;
  assign if_id_valid_o    = if_id_valid_q;
  assign if_id_pc_o       = if_id_pc_q;
  assign if_id_pc_plus4_o = if_id_pc_plus4_q;
  assign if_id_instr_o    = if_id_instr_q;
  assign pc_o             = pc_q;
  assign halted_o         = (state_q == ST_HALTED);

  // Next-state, PC, buffer and IF/ID update with halt > redirect > flush > normal priority.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    buf_valid_d      = buf_valid_q;
    buf_data_d       = buf_data_q;
    if_id_valid_d    = if_id_valid_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    if_id_instr_d    = if_id_instr_q;
`ifdef IFU_MISALIGN_CHECK_EN
    misaligned_d     = misaligned_q;
`endif
    if (state_q == ST_HALTED) begin
      state_d = ST_HALTED;
    end else if (halt_detected_i) begin
      state_d       = ST_HALTED;
      buf_valid_d   = 1'b0;
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
    end else if (redirect_req_i && target_misaligned) begin
      state_d       = ST_HALTED;
      pc_d          = target;
      buf_valid_d   = 1'b0;
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
`ifdef IFU_MISALIGN_CHECK_EN
      misaligned_d  = 1'b1;
`endif
    end else if (redirect_req_i) begin
      pc_d          = target;
      buf_valid_d   = 1'b0;
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
      // An outstanding request must have its response swallowed before refetching.
      case (state_q)
        ST_WAIT, ST_DROP: state_d = imem_rsp_valid_i ? ST_IDLE : ST_DROP;
        default:          state_d = ST_IDLE;
      endcase
    end else if (xfer) begin
      if_id_valid_d    = 1'b1;
      if_id_pc_d       = pc_q;
      if_id_pc_plus4_d = pc_plus4;
      if_id_instr_d    = fetch_data;
      buf_valid_d      = 1'b0;
      pc_d             = pc_plus4;
      state_d          = req_accept ? ST_WAIT : ST_IDLE;
    end else begin
      if (if_id_write_en_i) begin
        if_id_valid_d = 1'b0;
        if_id_instr_d = NOP_INSTR;
      end else begin
        if_id_valid_d = if_id_valid_q;
        if_id_instr_d = if_id_instr_q;
      end
      case (state_q)
        ST_WAIT: begin
          if (imem_rsp_valid_i) begin
            buf_valid_d = 1'b1;
            buf_data_d  = imem_rsp_data_i;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_DROP: state_d = imem_rsp_valid_i ? ST_IDLE : ST_DROP;
        ST_IDLE: state_d = req_accept ? ST_WAIT : ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= ST_IDLE;
      pc_q             <= RESET_PC;
      buf_valid_q      <= 1'b0;
      buf_data_q       <= 32'd0;
      if_id_valid_q    <= 1'b0;
      if_id_pc_q       <= 32'd0;
      if_id_pc_plus4_q <= 32'd4;
      if_id_instr_q    <= NOP_INSTR;
`ifdef IFU_MISALIGN_CHECK_EN
      misaligned_q     <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      buf_valid_q      <= buf_valid_d;
      buf_data_q       <= buf_data_d;
      if_id_valid_q    <= if_id_valid_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      if_id_instr_q    <= if_id_instr_d;
`ifdef IFU_MISALIGN_CHECK_EN
      misaligned_q     <= misaligned_d;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a bench-side memory returns
// address-tagged words; expected request addresses and IF/ID entries are queued.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_i;
  logic        pc_write_en_i;
  logic        if_id_write_en_i;
  logic        if_id_flush_i;
  logic        redirect_req_i;
  logic [31:0] redirect_target_i;
  logic        halt_detected_i;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc_plus4_o;
  logic [31:0] if_id_instr_o;
  logic [31:0] pc_o;
  logic        halted_o;
  logic        misaligned_o;

  instruction_fetch_unit dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .pc_write_en_i     (pc_write_en_i),
    .if_id_write_en_i  (if_id_write_en_i),
    .if_id_flush_i     (if_id_flush_i),
    .redirect_req_i    (redirect_req_i),
    .redirect_target_i (redirect_target_i),
    .halt_detected_i   (halt_detected_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_rsp_valid_i  (imem_rsp_valid_i),
    .imem_rsp_data_i   (imem_rsp_data_i),
    .if_id_valid_o     (if_id_valid_o),
    .if_id_pc_o        (if_id_pc_o),
    .if_id_pc_plus4_o  (if_id_pc_plus4_o),
    .if_id_instr_o     (if_id_instr_o),
    .pc_o              (pc_o),
    .halted_o          (halted_o),
    .misaligned_o      (misaligned_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] req_q[$];
  logic [31:0] ifid_q[$];

  bit          sb_on = 1'b0;
  bit          prev_we = 1'b1;
  bit          prev_rst = 1'b1;
  bit          acc = 1'b0;
  logic [31:0] acc_addr = 32'd0;
  int          lat = 1;
  bit          inj = 1'b0;
  bit          pend_v = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  int          pend_cnt = 0;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic set_defaults();
    pc_write_en_i     = 1'b1;
    if_id_write_en_i  = 1'b1;
    if_id_flush_i     = 1'b0;
    redirect_req_i    = 1'b0;
    redirect_target_i = 32'd0;
    halt_detected_i   = 1'b0;
    imem_req_ready_i  = 1'b1;
  endtask

  // Negedge sample: request acceptance and newly loaded IF/ID entries.
  task automatic half();
    logic [31:0] e;
    @(negedge clk);
    acc      = imem_req_valid_o && imem_req_ready_i;
    acc_addr = imem_req_addr_o;
    if (sb_on && acc && (req_q.size() > 0)) begin
      e = req_q.pop_front();
      check_eq("req_addr", acc_addr, e);
    end
    if (sb_on && if_id_valid_o && prev_we && !prev_rst) begin
      if (ifid_q.size() > 0) begin
        e = ifid_q.pop_front();
        check_eq("ifid_pc", if_id_pc_o, e);
        check_eq("ifid_pc4", if_id_pc_plus4_o, e + 32'd4);
        check_eq("ifid_instr", if_id_instr_o, tag(e));
      end else begin
        check_eq("ifid_unexpected", {31'd0, if_id_valid_o}, 32'd0);
      end
    end
  endtask

  // Posedge+1: advance the bench memory and record this cycle's controls.
  task automatic edge_step();
    @(posedge clk);
    #1;
    prev_we  = if_id_write_en_i;
    prev_rst = rst_i;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'd0;
    if (acc) begin
      pend_v    = 1'b1;
      pend_addr = acc_addr;
      pend_cnt  = lat;
    end
    if (pend_v) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = tag(pend_addr);
        pend_v           = 1'b0;
      end
    end
    if (inj) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = $urandom;
    end
  endtask

  task automatic tick();
    half();
    edge_step();
  endtask

  task automatic do_reset(input bit chk);
    rst_i = 1'b1;
    sb_on = 1'b0;
    inj   = 1'b0;
    lat   = 1;
    set_defaults();
    req_q.delete();
    ifid_q.delete();
    tick();
    pend_v           = 1'b0;
    imem_rsp_valid_i = 1'b0;
    half();
    if (chk) begin
      check_eq("rst_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
      check_eq("rst_ifid_valid", {31'd0, if_id_valid_o}, 32'd0);
      check_eq("rst_ifid_pc", if_id_pc_o, 32'd0);
      check_eq("rst_ifid_pc4", if_id_pc_plus4_o, 32'd4);
      check_eq("rst_ifid_instr", if_id_instr_o, NOP);
      check_eq("rst_pc", pc_o, 32'd0);
      check_eq("rst_halted", {31'd0, halted_o}, 32'd0);
      check_eq("rst_misaligned", {31'd0, misaligned_o}, 32'd0);
    end
    edge_step();
    rst_i = 1'b0;
    sb_on = 1'b1;
  endtask

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while ((ifid_q.size() > 0) && (n < budget)) begin
      tick();
      n++;
    end
    check_eq("ifid_drain", 32'(ifid_q.size()), 32'd0);
    check_eq("req_drain", 32'(req_q.size()), 32'd0);
  endtask

  initial begin
    rst_i            = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'd0;
    set_defaults();

    // Reset values, then back-to-back fetch with a single-cycle memory.
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      req_q.push_back(32'(i * 4));
      ifid_q.push_back(32'(i * 4));
    end
    run_drain(40);

    // IF/ID frozen while the first response returns: word buffered, no request.
    do_reset(1'b0);
    req_q.push_back(32'h0);   req_q.push_back(32'h4);
    ifid_q.push_back(32'h0);  ifid_q.push_back(32'h4);
    tick();
    if_id_write_en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      half();
      check_eq("stall_noreq", {31'd0, imem_req_valid_o}, 32'd0);
      check_eq("stall_hold", {31'd0, if_id_valid_o}, 32'd0);
      edge_step();
    end
    if_id_write_en_i = 1'b1;
    half();
    check_eq("release_noreq", {31'd0, imem_req_valid_o}, 32'd0);
    edge_step();
    run_drain(20);

    // Flush while a response returns: word kept in the buffer, PC unchanged.
    do_reset(1'b0);
    req_q.push_back(32'h0);   req_q.push_back(32'h4);
    ifid_q.push_back(32'h0);  ifid_q.push_back(32'h4);
    tick();
    if_id_flush_i = 1'b1;
    half();
    check_eq("flush_noreq", {31'd0, imem_req_valid_o}, 32'd0);
    edge_step();
    if_id_flush_i = 1'b0;
    half();
    check_eq("flush_pc_hold", pc_o, 32'd0);
    check_eq("flush_buf_noreq", {31'd0, imem_req_valid_o}, 32'd0);
    edge_step();
    run_drain(20);

    // Redirect with a request outstanding on a two-cycle memory.
    do_reset(1'b0);
    lat = 2;
    req_q.push_back(32'h0); req_q.push_back(32'h100); req_q.push_back(32'h104);
    ifid_q.push_back(32'h100); ifid_q.push_back(32'h104);
    tick();
    redirect_req_i    = 1'b1;
    redirect_target_i = 32'h0000_0100;
    tick();
    redirect_req_i = 1'b0;
    half();
    check_eq("drop_noreq", {31'd0, imem_req_valid_o}, 32'd0);
    check_eq("redirect_pc", pc_o, 32'h0000_0100);
    edge_step();
    run_drain(30);

    // Halt: bubble, halted, no further requests, stray responses ignored.
    do_reset(1'b0);
    req_q.push_back(32'h0); req_q.push_back(32'h4);
    ifid_q.push_back(32'h0);
    tick();
    tick();
    halt_detected_i = 1'b1;
    half();
    check_eq("halt_noreq", {31'd0, imem_req_valid_o}, 32'd0);
    edge_step();
    halt_detected_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      inj               = ((i % 3) == 0);
      redirect_req_i    = (i == 10);
      redirect_target_i = 32'h0000_0200;
      half();
      check_eq("halted_noreq", {31'd0, imem_req_valid_o}, 32'd0);
      check_eq("halted_flag", {31'd0, halted_o}, 32'd1);
      check_eq("halted_ifid_valid", {31'd0, if_id_valid_o}, 32'd0);
      check_eq("halted_ifid_instr", if_id_instr_o, NOP);
      edge_step();
    end
    inj            = 1'b0;
    redirect_req_i = 1'b0;
    half();
    check_eq("halted_pc_frozen", pc_o, 32'h0000_0004);
    edge_step();
    run_drain(5);

    // Memory not ready for four cycles: request and address held stable.
    do_reset(1'b0);
    req_q.push_back(32'h0); req_q.push_back(32'h4);
    ifid_q.push_back(32'h0);
    imem_req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      half();
      check_eq("nready_valid", {31'd0, imem_req_valid_o}, 32'd1);
      check_eq("nready_addr", imem_req_addr_o, 32'd0);
      edge_step();
    end
    imem_req_ready_i = 1'b1;
    run_drain(20);

    // PC wrap at the top of the address space.
    do_reset(1'b0);
    req_q.push_back(32'hFFFF_FFFC); req_q.push_back(32'h0); req_q.push_back(32'h4);
    ifid_q.push_back(32'hFFFF_FFFC); ifid_q.push_back(32'h0); ifid_q.push_back(32'h4);
    redirect_req_i    = 1'b1;
    redirect_target_i = 32'hFFFF_FFFC;
    tick();
    redirect_req_i = 1'b0;
    run_drain(20);

    // Redirect to a misaligned target.
    do_reset(1'b0);
    req_q.push_back(32'h0);
    tick();
    redirect_req_i    = 1'b1;
    redirect_target_i = 32'h0000_0102;
`ifndef IFU_MISALIGN_CHECK_EN
    req_q.push_back(32'h100);
    ifid_q.push_back(32'h100);
`endif
    tick();
    redirect_req_i = 1'b0;
    half();
`ifdef IFU_MISALIGN_CHECK_EN
    check_eq("mis_flag", {31'd0, misaligned_o}, 32'd1);
    check_eq("mis_halted", {31'd0, halted_o}, 32'd1);
    check_eq("mis_noreq", {31'd0, imem_req_valid_o}, 32'd0);
    check_eq("mis_pc", pc_o, 32'h0000_0102);
    edge_step();
    for (int i = 0; i < 4; i++) begin
      half();
      check_eq("mis_halted_noreq", {31'd0, imem_req_valid_o}, 32'd0);
      edge_step();
    end
`else
    check_eq("mis_flag", {31'd0, misaligned_o}, 32'd0);
    check_eq("mis_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
    check_eq("mis_req_addr", imem_req_addr_o, 32'h0000_0100);
    edge_step();
`endif
    run_drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage that owns the PC and the IF/ID pipeline register; sits directly upstream of the hazard/flow-control logic and consumes its pc_write_en/if_id_write_en/if_id_flush commands plus redirect/halt events.
- Issues instruction-memory requests over a valid/ready + response-valid interface, at most one outstanding.
- Holds an early-returning instruction in a one-entry buffer while IF/ID is frozen, and discards stale responses after a redirect or halt.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, encoding driven on if_id_instr_o for bubbles.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- pc_write_en_i  in  1  PC may advance (0 = freeze).
- if_id_write_en_i  in  1  IF/ID may update (0 = hold).
- if_id_flush_i  in  1  load bubble into IF/ID (when write enabled).
- redirect_req_i  in  1  branch/jump taken this cycle.
- redirect_target_i  in  32  new fetch PC.
- halt_detected_i  in  1  ECALL reached; stop fetching.
- imem_req_valid_o  out  1  request valid.
- imem_req_addr_o  out  32  request address.
- imem_req_ready_i  in  1  memory accepts request.
- imem_rsp_valid_i  in  1  response data valid (earliest: cycle after acceptance).
- imem_rsp_data_i  in  32  instruction word.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- if_id_pc_o  out  32  PC of IF/ID instruction.
- if_id_pc_plus4_o  out  32  if_id_pc_o + 4.
- if_id_instr_o  out  32  instruction word.
- pc_o  out  32  current fetch PC (pc_q).
- halted_o  out  1  fetch halted.
- misaligned_o  out  1  sticky misaligned-target flag (see Optional Feature).

Behaviour:
- Reset: pc_q=RESET_PC, state=IDLE, buf_valid=0, if_id_valid_o=0, if_id_pc_o=0, if_id_pc_plus4_o=4, if_id_instr_o=NOP_INSTR, halted_o=0, misaligned_o=0; imem_req_valid_o=0 while rst_i=1.
- States: IDLE (may request pc_q), WAIT (request outstanding), DROP (stale request outstanding, response discarded), HALTED.
- avail = (WAIT & imem_rsp_valid_i) | buf_valid; data = buf_valid ? buffer : imem_rsp_data_i.
- xfer = avail & if_id_write_en_i & pc_write_en_i & !if_id_flush_i & !redirect_req_i & !halt_detected_i.
- Request:
  - imem_req_valid_o = !redirect_req_i & !halt_detected_i & !buf_valid & (IDLE | (WAIT & xfer)).
  - Address is pc_q in IDLE, pc_q+4 on the WAIT&xfer path.
  - Address must not change while valid & !ready.
  - Acceptance -> WAIT; pc_q updates to the issued address.
- xfer: IF/ID <= {valid=1, pc=pc_q, instr=data, pc+4}; buf_valid<=0.
  - Without a new acceptance: pc_q<=pc_q+4, state->IDLE.
- Response in WAIT without xfer: word captured into buffer, state->IDLE (no new request until buffer drained).
- No avail, IF/ID write enabled, no flush: IF/ID <= bubble (valid=0, instr=NOP_INSTR); pc unchanged.
- if_id_write_en_i=0: IF/ID holds all fields.
- Priority in one cycle: rst_i > halt_detected_i > redirect_req_i > if_id_flush_i > normal.
- halt_detected_i: IF/ID <= bubble (flush); buffer cleared; state->HALTED; halted_o=1 next cycle; pc_q frozen.
  - HALTED ignores all responses and requests nothing; exit only by reset.
- redirect_req_i:
  - pc_q<=redirect_target_i; buffer cleared; IF/ID <= bubble.
  - WAIT without response this cycle -> DROP; WAIT with response -> IDLE (response ignored).
  - DROP stays DROP; IDLE stays IDLE.
- DROP: next imem_rsp_valid_i is discarded -> IDLE. Redirect during DROP updates pc_q, stays DROP.
- if_id_flush_i without redirect/halt: IF/ID <= bubble; any available word goes to/stays in the buffer; pc unchanged.
- pc arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Responses arriving in IDLE/HALTED are protocol errors; ignored.
- Throughput: 1 instr/cycle with ready=1 and single-cycle response.

Optional Feature:
- Macro IFU_MISALIGN_CHECK_EN.
- Defined: redirect with target[1:0]!=0 sets misaligned_o (sticky until reset), enters HALTED, no request to the target; pc_q latches the raw target.
- Undefined: target[1:0] forced to 2'b00; misaligned_o tied 0.

Test Plan:
- Reset, ready=1, 1-cycle memory returning addr-tagged words -> requests 0,4,8,… one per cycle; IF/ID pc 0,4,8 with matching instr, valid=1 from 2nd cycle after first accept.
- Response arrives while if_id_write_en_i=0 for 3 cycles -> IF/ID holds, word buffered, no new request; on release IF/ID gets buffered word, next request issued the following cycle.
- Redirect to 32'h0000_0100 with request outstanding (2-cycle memory) -> stale response discarded (DROP), next request addr 0x100, IF/ID bubble during gap.
- halt_detected_i pulse -> IF/ID valid=0 instr=NOP_INSTR, halted_o=1, imem_req_valid_o stays 0 for 20 cycles; responses ignored.
- imem_req_ready_i=0 for 4 cycles -> valid held high, address stable at 0; accepted on cycle 5.
- IFU_MISALIGN_CHECK_EN defined, redirect to 32'h0000_0102 -> misaligned_o=1, halted_o=1, no request to 0x102; undefined -> request address 0x100.
